// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, address default and MCS-51 opcode length table
package fetch_pkg;

    localparam int FETCH_ADDR_W = 12;

    typedef enum logic [2:0] {
        S_OP,
        S_B1,
        S_B2,
        S_B3,
        S_OUT
    } state_t;

    // Length is decoded per opcode-map column (low nibble), then by row (high nibble).
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        logic [1:0] len;
        hi  = op[7:4];
        lo  = op[3:0];
        len = 2'd1;
        case (lo)
            4'h0: begin
                if (hi inside {4'h1, 4'h2, 4'h3, 4'h9})              len = 2'd3;
                else if (hi inside {[4'h4:4'h8], [4'hA:4'hD]})       len = 2'd2;
            end
            4'h1: len = 2'd2;
            4'h2: begin
                if (hi inside {4'h0, 4'h1})                          len = 2'd3;
                else if (hi inside {[4'h4:4'hD]})                    len = 2'd2;
            end
            4'h3: begin
                if (hi inside {[4'h4:4'h6]})                         len = 2'd3;
            end
            4'h4: begin
                if (hi inside {[4'h2:4'h7], 4'h9})                   len = 2'd2;
                else if (hi == 4'hB)                                 len = 2'd3;
            end
            4'h5: begin
                if (hi inside {4'h7, 4'h8, 4'hB, 4'hD})              len = 2'd3;
                else if (hi != 4'hA)                                 len = 2'd2;
            end
            4'h6, 4'h7: begin
                if (hi inside {4'h7, 4'h8, 4'hA})                    len = 2'd2;
                else if (hi == 4'hB)                                 len = 2'd3;
            end
            default: begin
                if (hi inside {4'h7, 4'h8, 4'hA, 4'hD})              len = 2'd2;
                else if (hi == 4'hB)                                 len = 2'd3;
            end
        endcase
        return len;
    endfunction

endpackage

// File: rtl/op_len_rom.sv
// rtl/op_len_rom.sv - combinational opcode to instruction-length lookup
module op_len_rom
    import fetch_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    assign len = op_len(opcode);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - 8051 instruction fetch: ROM sequencing, length decode, valid/ready output
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [7:0]        instr_op1,
    output logic [7:0]        instr_op2,
    output logic [1:0]        instr_len,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_next_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        new_len;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_plus2;

    op_len_rom u_op_len (
        .opcode (rom_data),
        .len    (new_len)
    );

    assign pc_plus1 = pc + ADDR_W'(1);
    assign pc_plus2 = pc + ADDR_W'(2);

    // The opcode read is gated by rst so nothing is issued while the ROM image loads.
    always_comb begin
        rom_rd   = 1'b0;
        rom_addr = pc;
        case (state)
            S_OP: rom_rd = rst;
            S_B1: begin
                if (new_len != 2'd1) begin
                    rom_rd   = 1'b1;
                    rom_addr = pc_plus1;
                end
            end
            S_B2: begin
                if (instr_len == 2'd3) begin
                    rom_rd   = 1'b1;
                    rom_addr = pc_plus2;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_OP;
            pc            <= RESET_PC;
            instr_valid   <= 1'b0;
            instr_opcode  <= '0;
            instr_op1     <= '0;
            instr_op2     <= '0;
            instr_len     <= '0;
            instr_pc      <= '0;
            instr_next_pc <= '0;
        end else if (redirect_valid) begin
            state       <= S_OP;
            pc          <= redirect_pc;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_OP: state <= S_B1;
                S_B1: begin
                    instr_opcode  <= rom_data;
                    instr_op1     <= '0;
                    instr_op2     <= '0;
                    instr_len     <= new_len;
                    instr_pc      <= pc;
                    instr_next_pc <= pc + ADDR_W'(new_len);
                    if (new_len == 2'd1) begin
                        instr_valid <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        state <= S_B2;
                    end
                end
                S_B2: begin
                    instr_op1 <= rom_data;
                    if (instr_len == 2'd2) begin
                        instr_valid <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        state <= S_B3;
                    end
                end
                S_B3: begin
                    instr_op2   <= rom_data;
                    instr_valid <= 1'b1;
                    state       <= S_OUT;
                end
                S_OUT: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= instr_next_pc;
                        state       <= S_OP;
                    end
                end
                default: state <= S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a 1-cycle-latency ROM model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data = 8'h00;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_op1;
    logic [7:0]  instr_op2;
    logic [1:0]  instr_len;
    logic [11:0] instr_pc;
    logic [11:0] instr_next_pc;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = 12'h000;

    typedef struct packed {
        logic [7:0]  opc;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [1:0]  len;
        logic [11:0] pc;
        logic [11:0] npc;
    } exp_t;

    exp_t       exp_q[$];
    int         hs_cyc[$];
    logic [7:0] rom [0:4095];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;

    logic [7:0] sw_op  [20] = '{8'h00, 8'h01, 8'h10, 8'h22, 8'h43, 8'h73, 8'hA5, 8'hB4, 8'hD5, 8'hD8,
                                8'hB6, 8'h86, 8'hE0, 8'h12, 8'h75, 8'hC0, 8'hF5, 8'hA4, 8'h80, 8'h20};
    logic [1:0] sw_len [20] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd2,
                                2'd3, 2'd2, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd2, 2'd3};

    fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_rd         (rom_rd),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_opcode   (instr_opcode),
        .instr_op1      (instr_op1),
        .instr_op2      (instr_op2),
        .instr_len      (instr_len),
        .instr_pc       (instr_pc),
        .instr_next_pc  (instr_next_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Scoreboard: every accepted instruction must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_instr", 64'(instr_valid), 64'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_opcode",  instr_opcode,  e.opc);
                check("sb_op1",     instr_op1,     e.op1);
                check("sb_op2",     instr_op2,     e.op2);
                check("sb_len",     instr_len,     e.len);
                check("sb_pc",      instr_pc,      e.pc);
                check("sb_next_pc", instr_next_pc, e.npc);
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic reset_begin();
        rst            = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        exp_q.delete();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        @(negedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic place(input logic [11:0] at, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [1:0] len, input bit push,
                         output logic [11:0] next);
        exp_t        e;
        logic [11:0] a1;
        logic [11:0] a2;
        a1 = at + 12'd1;
        a2 = at + 12'd2;
        rom[at] = b0;
        if (len >= 2'd2) rom[a1] = b1;
        if (len == 2'd3) rom[a2] = b2;
        e.opc = b0;
        e.op1 = (len >= 2'd2) ? b1 : 8'h00;
        e.op2 = (len == 2'd3) ? b2 : 8'h00;
        e.len = len;
        e.pc  = at;
        e.npc = at + 12'(len);
        next  = e.npc;
        if (push) exp_q.push_back(e);
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (rnd) instr_ready = 1'($urandom_range(0, 1));
        end
        instr_ready = 1'b0;
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : main
        logic [11:0] npc;
        int          n;
        #1;

        // Reset values and first-instruction latency
        reset_begin();
        check("rst_rom_rd",   rom_rd,        1'b0);
        check("rst_rom_addr", rom_addr,      12'h000);
        check("rst_valid",    instr_valid,   1'b0);
        check("rst_fields",   {instr_opcode, instr_op1, instr_op2, instr_len}, 26'h0);
        check("rst_pcs",      {instr_pc, instr_next_pc}, 24'h0);
        place(12'h000, 8'h00, 8'h00, 8'h00, 2'd1, 1'b1, npc);
        release_rst();
        #1;
        check("t1_rom_rd_c0",   rom_rd,   1'b1);
        check("t1_rom_addr_c0", rom_addr, 12'h000);
        @(negedge clk);
        check("t1_valid_c1", instr_valid, 1'b0);
        @(negedge clk);
        check("t1_valid_c2", instr_valid, 1'b1);
        drain(1'b0, 20);

        // Back-to-back 2-byte then 3-byte instruction
        reset_begin();
        place(12'h000, 8'h24, 8'h05, 8'h00, 2'd2, 1'b1, npc);
        place(npc,     8'h85, 8'h18, 8'h35, 2'd3, 1'b1, npc);
        hs_cyc.delete();
        release_rst();
        drain(1'b0, 40);
        if (hs_cyc.size() == 2) check("t2_b2b_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'd5);
        else                    check("t2_hs_count", 64'(hs_cyc.size()), 64'd2);

        // Decoder stalls for 10 cycles
        reset_begin();
        place(12'h000, 8'h75, 8'h30, 8'h7F, 2'd3, 1'b1, npc);
        place(npc,     8'h04, 8'h00, 8'h00, 2'd1, 1'b1, npc);
        release_rst();
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_valid_seen", instr_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold", {rom_rd, instr_valid, instr_opcode, instr_op1, instr_op2, instr_pc},
                  {1'b0, 1'b1, 8'h75, 8'h30, 8'h7F, 12'h000});
        end
        drain(1'b0, 40);

        // Redirect during byte-2 fetch of an LJMP
        reset_begin();
        rom[0] = 8'h02;
        rom[1] = 8'h01;
        rom[2] = 8'h23;
        place(12'h100, 8'hA4, 8'h00, 8'h00, 2'd1, 1'b1, npc);
        release_rst();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t4_b2_rd",   rom_rd,   1'b1);
        check("t4_b2_addr", rom_addr, 12'h002);
        redirect_valid = 1'b1;
        redirect_pc    = 12'h100;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("t4_redir_rd",    rom_rd,      1'b1);
        check("t4_redir_addr",  rom_addr,    12'h100);
        check("t4_redir_valid", instr_valid, 1'b0);
        drain(1'b0, 20);

        // 3-byte instruction straddling the top of the address space
        reset_begin();
        place(12'hFFE, 8'h02, 8'h12, 8'h34, 2'd3, 1'b1, npc);
        release_rst();
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 12'hFFE;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("t5_redir_addr", rom_addr, 12'hFFE);
        drain(1'b0, 20);

        // Asynchronous reset in the middle of byte-2 fetch
        reset_begin();
        place(12'h000, 8'h90, 8'h12, 8'h34, 2'd3, 1'b0, npc);
        release_rst();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t6_pre_addr", rom_addr, 12'h002);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_rd",     rom_rd,       1'b0);
        check("t6_rst_addr",   rom_addr,     12'h000);
        check("t6_rst_valid",  instr_valid,  1'b0);
        check("t6_rst_opcode", instr_opcode, 8'h00);
        check("t6_rst_len",    instr_len,    2'd0);
        check("t6_rst_pc",     {instr_pc, instr_next_pc}, 24'h0);
        place(12'h000, 8'h90, 8'h12, 8'h34, 2'd3, 1'b1, npc);
        release_rst();
        drain(1'b0, 20);

        // Opcode length sweep with random decoder back-pressure
        reset_begin();
        npc = 12'h000;
        for (int i = 0; i < 20; i++) begin
            place(npc, sw_op[i], 8'($urandom), 8'($urandom), sw_len[i], 1'b1, npc);
        end
        release_rst();
        drain(1'b1, 2000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the program ROM in the 8051 core. Drives the ROM address/read strobe, captures the 1-cycle-latency byte stream, determines instruction length from the opcode (1–3 bytes) and presents each complete instruction to the decoder over a valid/ready handshake. Accepts branch redirects from the execute stage.

## Interface
- RESET_PC, 12'h000, PC loaded at reset
- ADDR_W, 12, program address width (4 KB space)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rom_addr  out  ADDR_W  byte address to ROM
- rom_rd  out  1  ROM read strobe
- rom_data  in  8  ROM read data, valid the cycle after the edge that sampled rom_addr with rom_rd=1
- instr_valid  out  1  complete instruction available
- instr_ready  in  1  decoder accepts instruction
- instr_opcode  out  8  byte 0
- instr_op1  out  8  byte 1 (0 if len<2)
- instr_op2  out  8  byte 2 (0 if len<3)
- instr_len  out  2  1, 2 or 3
- instr_pc  out  ADDR_W  address of opcode byte
- instr_next_pc  out  ADDR_W  instr_pc + instr_len, mod 2^ADDR_W
- redirect_valid  in  1  single-cycle branch/jump request
- redirect_pc  in  ADDR_W  new fetch address

## Operation
- Reset (rst=0): state S_OP, pc=RESET_PC, rom_rd=0, rom_addr=RESET_PC, instr_valid=0, all instr_* outputs 0. ROM image loads during reset; no read is issued until the first edge after rst deasserts.
- States: S_OP (issue opcode read), S_B1 (capture opcode, issue byte1 read if len≥2), S_B2 (capture byte1, issue byte2 read if len=3), S_B3 (capture byte2), S_OUT (hold instruction).
- S_OP: rom_addr=pc, rom_rd=1 → S_B1.
- S_B1: opcode=rom_data, len=op_len(opcode). len=1 → S_OUT; else rom_addr=pc+1, rom_rd=1 → S_B2.
- S_B2: op1=rom_data. len=2 → S_OUT; else rom_addr=pc+2, rom_rd=1 → S_B3.
- S_B3: op2=rom_data → S_OUT.
- S_OUT: instr_valid=1, outputs stable. On instr_ready: pc=instr_next_pc, → S_OP. Without ready: hold indefinitely, rom_rd=0.
- op_len per Intel MCS-51 opcode map; e.g. 0x00 NOP=1, 0xA4 MUL=1, 0x24 ADD A,#=2, 0x80 SJMP=2, 0x02 LJMP=3, 0x20 JB=3, 0x85 MOV dir,dir=3. 0xA5 (reserved) = 1.
- Address arithmetic wraps: pc+1, pc+2, next_pc all mod 2^ADDR_W (0xFFF+1 = 0x000).
- Redirect (any state): discard assembled bytes and any in-flight ROM data, instr_valid=0 next cycle, pc=redirect_pc, → S_OP. Redirect coincident with instr_valid&&instr_ready: handshake counts as accepted, redirect still wins for pc.
- rst asserted mid-instruction: immediate return to reset values; partial instruction lost.

## Timing
- rom_rd is high only in the cycle whose edge samples the address; rom_data consumed exactly one cycle later.
- From entering S_OP to instr_valid: len+1 cycles (1-byte: 2, 3-byte: 4).
- Back-to-back with instr_ready tied 1: one instruction every len+2 cycles (no fetch overlap).
- Redirect pulse at edge k: S_OP active cycle k+1, rom_addr=redirect_pc in that cycle.
- All outputs registered except rom_addr/rom_rd, which are decoded from state and pc.

## Structure
- Package fetch_pkg: state enum, ADDR_W default, op_len function (256-entry MCS-51 length table).
- Sub-module op_len_rom (combinational opcode→length lookup) is natural; instantiate once.

## Test plan
- Reset release, ROM {0x00}: rom_addr=0x000 cycle 0, instr_valid cycle 2, opcode 0x00, len 1, next_pc 0x001.
- ROM {0x24,0x05,0x85,0x18,0x35}, ready=1: instr (0x24,0x05,len2,pc0x000) then (0x85,0x18,0x35,len3,pc0x002,next_pc0x005).
- instr_ready held 0 for 10 cycles in S_OUT: outputs stable, rom_rd=0; release → next fetch at next_pc.
- Redirect to 0x100 during S_B2 of a 3-byte instr: no instr_valid for partial, next rom_addr=0x100.
- 3-byte opcode 0x02 at 0xFFE: bytes from 0xFFE,0xFFF,0x000; next_pc=0x001.
- rst low mid-S_B2: all outputs to reset values asynchronously; restart at RESET_PC.
